// File: rtl/whitening_mac_engine.sv
// Sequential N x N signed matrix product V = D x E_T using one multiplier and one accumulator,
// with arithmetic downshift and saturation per result element.
module whitening_mac_engine #(
  parameter int N          = 4,
  parameter int IW         = 64,
  parameter int OW         = 26,
  parameter int FRAC_SHIFT = 51
) (
  input  logic                  CLK_WME,
  input  logic                  RSTn_WME,
  input  logic                  En_WME,
  input  logic                  Start_WME,
  input  logic [N*N*IW-1:0]     D_inv_sqrt,
  input  logic [N*N*IW-1:0]     E_T,
  output logic [N*N*OW-1:0]     V,
  output logic                  Busy_WME,
  output logic                  Done_WME,
  output logic                  Sat_WME
);

  localparam int IDXW = $clog2(N);
  localparam int AW   = 2*IW + $clog2(N);
  localparam logic [IDXW-1:0]   LAST = IDXW'(N-1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_nxt;

  logic [N*N*IW-1:0]      d_q, e_q;
  logic [N*N*OW-1:0]      shadow;
  logic [IDXW-1:0]        r, c, k;
  logic signed [AW-1:0]   acc, acc_sum, prod_ext, sh;
  logic signed [IW-1:0]   op_a, op_b;
  logic signed [2*IW-1:0] prod;
  logic [OW-1:0]          res;
  logic                   sat_run, cur_sat, last_k, last_c, last_r;
  int                     ia, ib, is;

  always_comb begin
    ia       = (int'(r)*N + int'(k))*IW;
    ib       = (int'(k)*N + int'(c))*IW;
    is       = (int'(r)*N + int'(c))*OW;
    op_a     = d_q[ia +: IW];
    op_b     = e_q[ib +: IW];
    prod     = op_a * op_b;
    prod_ext = {{(AW-2*IW){prod[2*IW-1]}}, prod};
    // k=0 starts a fresh dot product, so the stale accumulator is ignored
    acc_sum  = (k == '0) ? prod_ext : acc + prod_ext;
    sh       = acc_sum >>> FRAC_SHIFT;
    cur_sat  = (sh > MAXV) || (sh < MINV);
    if (sh > MAXV)      res = MAXV[OW-1:0];
    else if (sh < MINV) res = MINV[OW-1:0];
    else                res = sh[OW-1:0];
    last_k   = (k == LAST);
    last_c   = (c == LAST);
    last_r   = (r == LAST);
  end

  always_ff @(posedge CLK_WME or negedge RSTn_WME) begin
    if (!RSTn_WME) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (En_WME && Start_WME) state_nxt = MAC;
      MAC:     if (En_WME && last_r && last_c && last_k) state_nxt = DONE;
      DONE:    if (En_WME) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy_WME = (state != IDLE);
  assign Done_WME = (state == DONE);

  always_ff @(posedge CLK_WME or negedge RSTn_WME) begin
    if (!RSTn_WME) begin
      d_q     <= '0;
      e_q     <= '0;
      shadow  <= '0;
      V       <= '0;
      acc     <= '0;
      r       <= '0;
      c       <= '0;
      k       <= '0;
      sat_run <= 1'b0;
      Sat_WME <= 1'b0;
    end else if (En_WME) begin
      case (state)
        IDLE: if (Start_WME) begin
          d_q     <= D_inv_sqrt;
          e_q     <= E_T;
          acc     <= '0;
          r       <= '0;
          c       <= '0;
          k       <= '0;
          sat_run <= 1'b0;
          Sat_WME <= 1'b0;
        end
        MAC: begin
          acc <= acc_sum;
          if (last_k) begin
            k <= '0;
            shadow[is +: OW] <= res;
            sat_run <= sat_run | cur_sat;
            if (last_c) begin
              c <= '0;
              if (last_r) begin
                r <= '0;
                // last element is still in flight, so patch it into the publish copy
                V <= shadow;
                V[(N*N-1)*OW +: OW] <= res;
                Sat_WME <= sat_run | cur_sat;
              end else begin
                r <= r + 1'b1;
              end
            end else begin
              c <= c + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_whitening_mac_engine.sv
// Scoreboard bench for whitening_mac_engine: default N=4 instance plus a small N=2 instance.
module tb_whitening_mac_engine;

  localparam int N  = 4;
  localparam int IW = 64;
  localparam int OW = 26;
  localparam int DW = N*N*IW;
  localparam int VW = N*N*OW;

  typedef struct {
    logic [VW-1:0] v;
    logic          sat;
  } exp_t;

  logic clk, rst_n, en, start, busy, done, sat;
  logic [DW-1:0] d, e;
  logic [VW-1:0] v;
  logic en2, start2, busy2, done2, sat2;
  logic [63:0] d2, e2;
  logic [31:0] v2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  whitening_mac_engine dut (
    .CLK_WME(clk), .RSTn_WME(rst_n), .En_WME(en), .Start_WME(start),
    .D_inv_sqrt(d), .E_T(e), .V(v),
    .Busy_WME(busy), .Done_WME(done), .Sat_WME(sat)
  );

  whitening_mac_engine #(.N(2), .IW(16), .OW(8), .FRAC_SHIFT(0)) dut2 (
    .CLK_WME(clk), .RSTn_WME(rst_n), .En_WME(en2), .Start_WME(start2),
    .D_inv_sqrt(d2), .E_T(e2), .V(v2),
    .Busy_WME(busy2), .Done_WME(done2), .Sat_WME(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: floor(sum_k D(r,k)*E_T(k,c) / 2^51), clamped to OW-bit signed range
  function automatic exp_t model(input logic [DW-1:0] dm, input logic [DW-1:0] em);
    exp_t x;
    logic signed [131:0] a, b, acc, s;
    x.v   = '0;
    x.sat = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
          a   = $signed(dm[(r*N+k)*IW +: IW]);
          b   = $signed(em[(k*N+c)*IW +: IW]);
          acc = acc + a*b;
        end
        s = acc >>> 51;
        if (s > 132'sd33554431) begin
          x.v[(r*N+c)*OW +: OW] = 26'h1FFFFFF;
          x.sat = 1'b1;
        end else if (s < -132'sd33554432) begin
          x.v[(r*N+c)*OW +: OW] = 26'h2000000;
          x.sat = 1'b1;
        end else begin
          x.v[(r*N+c)*OW +: OW] = s[OW-1:0];
        end
      end
    end
    return x;
  endfunction

  // One run: stall_at >= 0 drops En for 10 edges; noisy changes operands and pulses Start mid-run
  task automatic do_run(input logic [DW-1:0] dm, input logic [DW-1:0] em, input int stall_at,
                        input bit noisy, input int exp_lat, input string tag);
    exp_t          ex;
    logic [VW-1:0] v_prev;
    int            edges;
    v_prev = v;
    d = dm; e = em; start = 1'b1; en = 1'b1;
    sb.push_back(model(dm, em));
    tick();
    start = 1'b0;
    edges = 0;
    chk({tag, "_busy_acc"}, busy, 1);
    if (noisy) begin
      d = ~dm;
      e = {N*N{$urandom}};
    end
    while (!done && edges < 300) begin
      if (edges == stall_at) en = 1'b0;
      if (edges == stall_at + 10) en = 1'b1;
      if (noisy) start = (edges == 4 || edges == 29);
      tick();
      edges++;
      if (edges == 20) chk({tag, "_v_hold"}, v, v_prev);
    end
    en = 1'b1;
    start = 1'b0;
    chk({tag, "_latency"}, edges, exp_lat);
    ex = sb.pop_front();
    chk({tag, "_v"}, v, ex.v);
    chk({tag, "_sat"}, sat, ex.sat);
    en = 1'b0;
    tick();
    chk({tag, "_done_stall"}, done, 1);
    en = 1'b1;
    start = 1'b1;
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    start = 1'b0;
    tick();
    chk({tag, "_no_restart"}, busy, 0);
  endtask

  logic [DW-1:0] d_id, e_seq, e_sat, d_rnd, e_rnd;
  longint        rv;

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; d = '0; e = '0;
    en2 = 1'b0; start2 = 1'b0; d2 = '0; e2 = '0;
    d_id = '0; e_seq = '0; e_sat = '0; d_rnd = '0; e_rnd = '0;
    for (int i = 0; i < N; i++) d_id[(i*N+i)*IW +: IW] = 64'h0008_0000_0000_0000;
    for (int i = 0; i < N*N; i++) e_seq[i*IW +: IW] = 64'(i+1);
    e_sat[0 +: IW]    = 64'h0000_0100_0000_0000;
    e_sat[5*IW +: IW] = 64'hFFFF_FF00_0000_0000;
    for (int i = 0; i < N*N; i++) begin
      rv = {$urandom, $urandom};
      d_rnd[i*IW +: IW] = rv >>> 23;
      rv = {$urandom, $urandom};
      e_rnd[i*IW +: IW] = rv >>> 33;
    end

    #2;
    chk("rst_v", v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    tick();
    rst_n = 1'b1;
    tick();

    do_run(d_id, e_seq, -1, 1'b0, 64, "ident");
    chk("ident_v11", v[5*OW +: OW], 26'd6);
    do_run(d_id, e_sat, -1, 1'b0, 64, "satur");
    chk("satur_v00", v[0 +: OW], 26'd33554431);
    chk("satur_v11", v[5*OW +: OW], 26'h2000000);
    do_run(d_id, e_seq, 30, 1'b0, 74, "stall");
    do_run(d_id, e_seq, -1, 1'b1, 64, "noisy");
    do_run(d_rnd, e_rnd, -1, 1'b0, 64, "rand");
    do_run(d_id, e_sat, -1, 1'b0, 64, "presat");

    // abort a run with reset mid-MAC; nothing must survive
    d = d_id; e = e_seq; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_v", v, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sat", sat, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_run(d_id, e_seq, -1, 1'b0, 64, "restart");

    // N=2 instance, unit shift
    d2 = {16'sd4, 16'sd1, -16'sd2, 16'sd3};
    e2 = {-16'sd8, 16'sd7, 16'sd6, 16'sd5};
    en2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    begin
      int edges;
      edges = 0;
      while (!done2 && edges < 50) begin
        tick();
        edges++;
      end
      chk("n2_latency", edges, 8);
    end
    chk("n2_v", v2, {-8'sd26, 8'sd33, 8'sd34, 8'sd1});
    chk("n2_sat", sat2, 0);
    tick();
    chk("n2_done_pulse", done2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/whitening_mac_engine.md
WHITENING_MAC_ENGINE -- requirements
Module: whitening_mac_engine

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension (N x N operands and result), legal range 2..8.
REQ-002 SHALL have parameter IW, default 64, signed operand element width.
REQ-003 SHALL have parameter OW, default 26, signed result element width.
REQ-004 SHALL have parameter FRAC_SHIFT, default 51, arithmetic right shift applied to each accumulated sum before narrowing.
REQ-005 SHALL have port CLK_WME  input  1  sole clock, rising edge.
REQ-006 SHALL have port RSTn_WME  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port En_WME  input  1  run enable; low stalls the engine in place.
REQ-008 SHALL have port Start_WME  input  1  start request, sampled only in IDLE.
REQ-009 SHALL have port D_inv_sqrt  input  N*N*IW  signed matrix D, element (r,c) at bits [(r*N+c)*IW +: IW].
REQ-010 SHALL have port E_T  input  N*N*IW  signed matrix E_T, same packing as D_inv_sqrt.
REQ-011 SHALL have port V  output  N*N*OW  signed result V = D x E_T, element (r,c) at bits [(r*N+c)*OW +: OW].
REQ-012 SHALL have port Busy_WME  output  1  high while a run is in progress.
REQ-013 SHALL have port Done_WME  output  1  single-cycle completion pulse.
REQ-014 SHALL have port Sat_WME  output  1  high if any element of the last completed run saturated.

Function
REQ-015 SHALL implement FSM states IDLE, MAC, DONE; IDLE->MAC on a rising edge with Start_WME=1 and En_WME=1; MAC->DONE on the edge that performs the last MAC; DONE->IDLE on the next edge that has En_WME=1.
REQ-016 SHALL capture D_inv_sqrt and E_T into internal registers on the accepting edge; input changes after that edge SHALL NOT affect the run.
REQ-017 SHALL use one signed IW x IW multiplier and one accumulator of width 2*IW + clog2(N), one product per MAC-state edge with En_WME=1.
REQ-018 SHALL iterate r (outer), c, k (inner), each from 0 to N-1: acc = sum over k of D(r,k)*E_T(k,c); acc cleared at k=0.
REQ-019 SHALL, at k=N-1, form s = acc >>> FRAC_SHIFT (floor); if s > 2^(OW-1)-1 store 2^(OW-1)-1, if s < -2^(OW-1) store -2^(OW-1), else store s[OW-1:0], into a shadow array.
REQ-020 SHALL copy the whole shadow array to V on the edge entering DONE; V SHALL otherwise hold its value, including throughout a run.
REQ-021 SHALL set Sat_WME on the edge entering DONE to the OR of all saturation events of that run, cleared on the accepting edge.
REQ-022 Busy_WME SHALL be 1 in MAC and DONE, 0 in IDLE; Done_WME SHALL be 1 only in DONE.
REQ-023 With En_WME held high, Done_WME SHALL rise exactly N^3 edges after the accepting edge (64 for N=4); each edge with En_WME=0 adds one cycle of latency.
REQ-024 En_WME=0 SHALL freeze state, indices, accumulator, shadow array and outputs; Done_WME SHALL stay high while stalled in DONE.
REQ-025 Start_WME while Busy_WME=1 SHALL be ignored; Start_WME=1 in DONE SHALL NOT start a run (IDLE must be reached first).

Reset
REQ-026 RSTn_WME=0 SHALL immediately force IDLE, indices and accumulator to 0, V to all zeros, Busy_WME=0, Done_WME=0, Sat_WME=0, regardless of clock or En_WME.
REQ-027 Reset asserted mid-run SHALL abort the run with no partial result reaching V; first start after release SHALL behave as from power-up.

Verification
REQ-028 N=4 defaults, D = 2^51*I, E_T(r,c) = r*4+c+1, start -> Done_WME after 64 edges, V(r,c) = r*4+c+1, Sat_WME=0.
REQ-029 D = 2^51*I, E_T(0,0) = 2^40, E_T(1,1) = -2^40, rest 0 -> V(0,0) = 33554431, V(1,1) = -33554432, others 0, Sat_WME=1.
REQ-030 Run of REQ-028 with En_WME low for 10 cycles mid-run -> Done_WME after 74 edges, identical V; V unchanged until DONE.
REQ-031 Start_WME pulsed at cycles 5 and 30 of a run and inputs changed after acceptance -> single Done_WME pulse, V from originally captured operands.
REQ-032 RSTn_WME low at MAC cycle 20 -> all outputs 0 immediately; restart with REQ-028 operands -> correct V after 64 edges.
REQ-033 N=2, IW=16, OW=8, FRAC_SHIFT=0, D = [[3,-2],[1,4]], E_T = [[5,6],[7,-8]] -> Done_WME after 8 edges, V = [[1,34],[33,-26]], Sat_WME=0.
